// File: rtl/mem_req.sv
// mem_req: memory-stage part 1. Holds the M1/M2 pipeline registers and drives the data SRAM request.
// Define MEM_ADDR_CHECK_EN to enable misaligned-access fault detection (ADEL/ADES).
module mem_req (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_ex,
    input  logic        stall_mem,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_wreg_addr,
    input  logic        ex_wreg_en,
    input  logic [31:0] ex_pc,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic        m2_valid,
    output logic [2:0]  m2_load_op,
    output logic [1:0]  m2_byte_off,
    output logic [4:0]  m2_wreg_addr,
    output logic        m2_wreg_en,
    output logic [31:0] m2_pc,
    output logic        mem_exc_adel,
    output logic        mem_exc_ades,
    output logic [31:0] mem_badvaddr
);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd9,
        OP_SH   = 4'd10,
        OP_SW   = 4'd11
    } mem_op_e;

    logic        m1_valid_q, m1_valid_d;
    logic [3:0]  m1_op_q, m1_op_d;
    logic [31:0] m1_addr_q, m1_addr_d;
    logic [31:0] m1_data_q, m1_data_d;
    logic [4:0]  m1_wreg_addr_q, m1_wreg_addr_d;
    logic        m1_wreg_en_q, m1_wreg_en_d;
    logic [31:0] m1_pc_q, m1_pc_d;
    logic        issued_q, issued_d;

    logic        m2_valid_q, m2_valid_d;
    logic [2:0]  m2_load_op_q, m2_load_op_d;
    logic [1:0]  m2_byte_off_q, m2_byte_off_d;
    logic [4:0]  m2_wreg_addr_q, m2_wreg_addr_d;
    logic        m2_wreg_en_q, m2_wreg_en_d;
    logic [31:0] m2_pc_q, m2_pc_d;

    logic        is_load, is_store, is_half, is_word;
    logic [2:0]  load_op;
    logic [3:0]  lane_wen;
    logic [31:0] lane_wdata;
    logic        fault;
    logic        req;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_half    = 1'b0;
        is_word    = 1'b0;
        load_op    = 3'd0;
        lane_wen   = '0;
        lane_wdata = m1_data_q;
        case (m1_op_q)
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
                load_op = m1_op_q[2:0];
            end
            OP_LH, OP_LHU: begin
                is_load = 1'b1;
                is_half = 1'b1;
                load_op = m1_op_q[2:0];
            end
            OP_LW: begin
                is_load = 1'b1;
                is_word = 1'b1;
                load_op = m1_op_q[2:0];
            end
            OP_SB: begin
                is_store   = 1'b1;
                lane_wen   = 4'b0001 << m1_addr_q[1:0];
                lane_wdata = {4{m1_data_q[7:0]}};
            end
            OP_SH: begin
                is_store   = 1'b1;
                is_half    = 1'b1;
                lane_wen   = m1_addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{m1_data_q[15:0]}};
            end
            OP_SW: begin
                is_store   = 1'b1;
                is_word    = 1'b1;
                lane_wen   = 4'b1111;
            end
            default: ;
        endcase
    end

`ifdef MEM_ADDR_CHECK_EN
    assign fault = m1_valid_q && ((is_half && m1_addr_q[0]) ||
                                  (is_word && (m1_addr_q[1:0] != 2'b00)));
`else
    assign fault = 1'b0;
`endif

    // issued_q blocks a repeat request while the same entry is held by stall_mem
    assign req = m1_valid_q && (is_load || is_store) && !flush && !issued_q && !fault;

    always_comb begin
        m1_valid_d     = m1_valid_q;
        m1_op_d        = m1_op_q;
        m1_addr_d      = m1_addr_q;
        m1_data_d      = m1_data_q;
        m1_wreg_addr_d = m1_wreg_addr_q;
        m1_wreg_en_d   = m1_wreg_en_q;
        m1_pc_d        = m1_pc_q;
        issued_d       = issued_q;
        m2_valid_d     = m2_valid_q;
        m2_load_op_d   = m2_load_op_q;
        m2_byte_off_d  = m2_byte_off_q;
        m2_wreg_addr_d = m2_wreg_addr_q;
        m2_wreg_en_d   = m2_wreg_en_q;
        m2_pc_d        = m2_pc_q;
        if (!stall_mem) begin
            m1_valid_d     = ex_valid && !stall_ex;
            m1_op_d        = ex_mem_op;
            m1_addr_d      = ex_addr;
            m1_data_d      = ex_store_data;
            m1_wreg_addr_d = ex_wreg_addr;
            m1_wreg_en_d   = ex_wreg_en;
            m1_pc_d        = ex_pc;
            issued_d       = 1'b0;
            m2_valid_d     = m1_valid_q;
            m2_load_op_d   = load_op;
            m2_byte_off_d  = m1_addr_q[1:0];
            m2_wreg_addr_d = m1_wreg_addr_q;
            m2_wreg_en_d   = m1_wreg_en_q && !fault;
            m2_pc_d        = m1_pc_q;
        end else if (req) begin
            issued_d = 1'b1;
        end
        if (flush) begin
            m1_valid_d = 1'b0;
            m2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_valid_q     <= 1'b0;
            m1_op_q        <= '0;
            m1_addr_q      <= '0;
            m1_data_q      <= '0;
            m1_wreg_addr_q <= '0;
            m1_wreg_en_q   <= 1'b0;
            m1_pc_q        <= '0;
            issued_q       <= 1'b0;
            m2_valid_q     <= 1'b0;
            m2_load_op_q   <= '0;
            m2_byte_off_q  <= '0;
            m2_wreg_addr_q <= '0;
            m2_wreg_en_q   <= 1'b0;
            m2_pc_q        <= '0;
        end else begin
            m1_valid_q     <= m1_valid_d;
            m1_op_q        <= m1_op_d;
            m1_addr_q      <= m1_addr_d;
            m1_data_q      <= m1_data_d;
            m1_wreg_addr_q <= m1_wreg_addr_d;
            m1_wreg_en_q   <= m1_wreg_en_d;
            m1_pc_q        <= m1_pc_d;
            issued_q       <= issued_d;
            m2_valid_q     <= m2_valid_d;
            m2_load_op_q   <= m2_load_op_d;
            m2_byte_off_q  <= m2_byte_off_d;
            m2_wreg_addr_q <= m2_wreg_addr_d;
            m2_wreg_en_q   <= m2_wreg_en_d;
            m2_pc_q        <= m2_pc_d;
        end
    end

    always_comb begin
        data_sram_en    = req;
        data_sram_wen   = req ? lane_wen : 4'b0000;
        data_sram_addr  = {m1_addr_q[31:2], 2'b00};
        data_sram_wdata = lane_wdata;
        m2_valid        = m2_valid_q;
        m2_load_op      = m2_load_op_q;
        m2_byte_off     = m2_byte_off_q;
        m2_wreg_addr    = m2_wreg_addr_q;
        m2_wreg_en      = m2_wreg_en_q;
        m2_pc           = m2_pc_q;
        mem_exc_adel    = fault && is_load;
        mem_exc_ades    = fault && is_store;
        mem_badvaddr    = fault ? m1_addr_q : '0;
    end

endmodule

// File: doc/mem_req.md
# mem_req

Memory-stage part 1 of the CPU pipeline. Registers the EX-stage load/store request and drives the synchronous data SRAM request: enable, byte write-enable, word address and lane-replicated write data. Carries load type and byte offset one more stage into memory-stage part 2, where the SRAM read data returns and is extracted. With the configuration macro defined, it also detects misaligned accesses.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all registers update on the rising edge
- rst  in  1  asynchronous, active-high reset
- stall_ex  in  1  EX stage held this cycle
- stall_mem  in  1  this stage (M1) held this cycle
- flush  in  1  exception/ertn flush; kills M1 and M2 contents
- ex_valid  in  1  EX carries a real instruction
- ex_mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 9 SB, 10 SH, 11 SW; other codes are treated as none
- ex_addr  in  32  effective address
- ex_store_data  in  32  rt value for stores
- ex_wreg_addr  in  5  destination register
- ex_wreg_en  in  1  writes a destination register
- ex_pc  in  32  instruction PC
- data_sram_en  out  1  SRAM access strobe
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  word address, {addr[31:2],2'b00}
- data_sram_wdata  out  32  lane-replicated store data
- m2_valid, m2_load_op[2:0], m2_byte_off[1:0], m2_wreg_addr[4:0], m2_wreg_en, m2_pc[31:0]  out  M2 register contents
- mem_exc_adel, mem_exc_ades  out  1  misaligned load / store in M1
- mem_badvaddr  out  32  faulting address

## Operation
- M1 register (valid, op, addr, store data, wreg, pc) loads from EX when !stall_mem.
- If stall_ex && !stall_mem, M1 loads a bubble (valid=0).
- M2 register loads from M1 when !stall_mem. When stall_mem, both M1 and M2 hold.
- flush: M1.valid and M2.valid clear at the next edge. flush overrides stall.
- Request is driven combinationally from the M1 register. A request is issued when M1.valid && op≠none && !flush && !issued && !fault.
- issued flag:
  - Set at the edge where a request is issued while stall_mem=1.
  - Cleared whenever M1 loads new contents.
  - Purpose: a store held by a stall writes exactly once. Held loads rely on part 2 holding the returned data.
- Byte enables and write data:
  - SB: wen = 4'b0001<<addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: wen = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - SW: wen = 4'b1111; wdata = data.
  - Loads: wen = 0; en = 1.
- m2_load_op: LB=1, LBU=2, LH=3, LHU=4, LW=5; 0 for stores and none. m2_byte_off = M1.addr[1:0].

## Timing
- Reset: all registers, issued, and every output are 0; data_sram_addr is 0.
- Latency: EX at edge N → M1 request during cycle N+1 → SRAM data and M2 info valid during cycle N+2.
- Stall mid-store: wen asserts only in the first held cycle and stays 0 for the rest of the stall. en follows the same rule.
- Reset asserted mid-stall drops en/wen immediately (asynchronously).
- Simultaneous flush and stall_mem: flush wins; outputs are suppressed in that same cycle.

## Configuration
- MEM_ADDR_CHECK_EN defined:
  - LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0, is a fault.
  - A fault suppresses en/wen, asserts mem_exc_adel (loads) or mem_exc_ades (stores) and mem_badvaddr=addr while M1.valid.
  - The entry proceeds to M2 with m2_wreg_en=0.
- MEM_ADDR_CHECK_EN undefined:
  - No fault detection; exception outputs are tied to 0.
  - Misaligned accesses use the word address and the lane rules above.

## Test plan
- SB addr 0x1000_0003, data 0x0000_00A5 → next cycle en=1, wen=4'b1000, addr 0x1000_0000, wdata 0xA5A5_A5A5.
- LHU addr 0x2002 → M1 en=1, wen=0; following cycle m2_load_op=4, m2_byte_off=2, m2_valid=1.
- SW 0xDEADBEEF with stall_mem held 3 cycles → wen=4'hF in exactly one cycle; M1 holds throughout.
- stall_ex=1, stall_mem=0 after an LW → M1 valid drops next edge; no second request.
- flush in the same cycle an SH sits in M1 → en=wen=0 that cycle; M1 and M2 valid clear next edge.
- With macro: LW addr 0x1002 → en=0, mem_exc_adel=1, mem_badvaddr=0x1002, m2_wreg_en=0.
- Without macro: the same LW → en=1, addr 0x1000, exception outputs 0.
